melody_sequencer: RTL

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_pkg.sv | 46 ++++
 rtl/melody_sequencer_tone_gen.sv | 47 ++++
 rtl/melody_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// Shared types and the built-in note table for melody_sequencer.
// A note entry packs {div[14:0], dur[9:0]}; dur==0 marks end of melody.
package melody_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [14:0] div;
    logic [9:0]  dur;
  } note_t;

  localparam int NOTES_MAX   = 256;
  localparam int TABLE_NOTES = 16;

  typedef note_t [NOTES_MAX-1:0] note_table_t;

  // Listed from entry 15 down to entry 0; divisors assume a 25 MHz clock.
  localparam note_t [TABLE_NOTES-1:0] NOTE_TABLE = {
    15'd0,     10'd0,
    15'd0,     10'd0,
    15'd0,     10'd0,
    15'd0,     10'd0,
    15'd11938, 10'd400,
    15'd15943, 10'd200,
    15'd0,     10'd100,
    15'd17907, 10'd200,
    15'd18967, 10'd200,
    15'd21293, 10'd200,
    15'd23900, 10'd400,
    15'd0,     10'd100,
    15'd15943, 10'd200,
    15'd18967, 10'd200,
    15'd21293, 10'd200,
    15'd23900, 10'd200
  };

  localparam note_table_t DEFAULT_TABLE =
    {{((NOTES_MAX - TABLE_NOTES) * $bits(note_t)){1'b0}}, NOTE_TABLE};

endpackage

// File: rtl/melody_sequencer_tone_gen.sv
// Square-wave tone generator: half-period of div+1 clk cycles while en is high.
// div==0 is a rest; the output is gated low whenever en is low.
module tone_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [14:0] div,
  output logic        speaker
);

  logic [14:0] cnt_q, cnt_d;
  logic        spk_q, spk_d;
  logic        en_q;

  always_comb begin
    cnt_d = cnt_q;
    spk_d = spk_q;
    if (!en) begin
      cnt_d = '0;
      spk_d = 1'b0;
    end else if (!en_q) begin
      cnt_d = div;
      spk_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d = div;
      spk_d = (div != '0) ? ~spk_q : 1'b0;
    end else begin
      cnt_d = cnt_q - 15'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spk_q <= spk_d;
      en_q  <= en;
    end
  end

  // Gating with en keeps the output silent the moment PLAY is left or reset hits.
  assign speaker = spk_q & en;

endmodule

// File: rtl/melody_sequencer.sv
// Note-table melody player: FSM, tick prescaler and duration counter driving tone_gen.
// Define MELODY_LOOP_EN to loop the melody forever instead of finishing in DONE.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25000,
  parameter int unsigned GAP_TICKS = 20,
  parameter int unsigned NOTES     = 16,
  parameter note_table_t TABLE     = DEFAULT_TABLE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NOTES)-1:0] note_idx,
  output logic                     speaker
);

  localparam int IDX_W = $clog2(NOTES);
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX  = (GAP_TICKS > 1024) ? GAP_TICKS : 1024;
  localparam int TW    = $clog2(TMAX);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [14:0]       div_q, div_d;
  logic [9:0]        dur_q, dur_d;
  logic [TW-1:0]     limit;
  logic              tick_wrap;
  logic              phase_end;
  note_t             entry;

  assign entry     = TABLE[idx_q];
  assign limit     = (state_q == S_PLAY) ? (TW'(dur_q) - TW'(1)) : TW'(GAP_TICKS - 1);
  assign tick_wrap = (presc_q == PW'(TICK_DIV - 1));
  assign phase_end = tick_wrap && (tick_q == limit);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    tick_d  = tick_q;
    div_d   = div_q;
    dur_d   = dur_q;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        presc_d = '0;
        tick_d  = '0;
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        div_d   = entry.div;
        dur_d   = entry.dur;
        presc_d = '0;
        tick_d  = '0;
        if (entry.dur == '0) begin
`ifdef MELODY_LOOP_EN
          idx_d   = '0;
          state_d = S_LOAD;
          done    = 1'b1;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_PLAY;
        end
      end
      S_PLAY, S_GAP: begin
        if (tick_wrap) begin
          presc_d = '0;
          tick_d  = tick_q + 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        // Both phases restart the prescaler so each lasts an exact multiple of TICK_DIV.
        if (phase_end) begin
          presc_d = '0;
          tick_d  = '0;
          if (state_q == S_PLAY) begin
            state_d = S_GAP;
          end else if (idx_q == IDX_W'(NOTES - 1)) begin
`ifdef MELODY_LOOP_EN
            idx_d   = '0;
            state_d = S_LOAD;
            done    = 1'b1;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d = S_IDLE;
      presc_d = '0;
      tick_d  = '0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      presc_q <= '0;
      tick_q  <= '0;
      div_q   <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
      dur_q   <= dur_d;
    end
  end

  assign busy     = (state_q == S_LOAD) || (state_q == S_PLAY) || (state_q == S_GAP);
  assign note_idx = idx_q;

  tone_gen u_tone_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == S_PLAY),
    .div     (div_q),
    .speaker (speaker)
  );

endmodule
